// File: rtl/data_mem_bytewise_pkg.sv
// Shared encodings and helpers for the MIPS byte-addressable data memory.
// Access sizes, clear sequencer states and a constant log2 helper.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } clr_state_t;

    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_bytewise_if.sv
// Load/store bus between the MEM stage and the data memory.
// The master issues requests; the slave returns load data and status.
interface data_mem_bytewise_if #(
    parameter int LEN_DATA = 32,
    parameter int AW       = 10
);
    logic                Rd;
    logic                Wr;
    logic [AW-1:0]       Addr;
    logic [1:0]          Size;
    logic                Unsigned;
    logic [LEN_DATA-1:0] In_Data;
    logic [LEN_DATA-1:0] Out_Data;
    logic                Misaligned;
    logic                Busy;

    modport master (
        output Rd, Wr, Addr, Size, Unsigned, In_Data,
        input  Out_Data, Misaligned, Busy
    );

    modport slave (
        input  Rd, Wr, Addr, Size, Unsigned, In_Data,
        output Out_Data, Misaligned, Busy
    );
endinterface

// File: rtl/data_mem_bytewise_bram.sv
// Byte-enabled read-first RAM with a second read-only port.
// Port A serves loads/stores/clear; port B serves the debug dump.
module data_mem_bram #(
    parameter int LEN_DATA = 32,
    parameter int DEPTH    = 256,
    parameter int NB       = LEN_DATA / 8,
    parameter int WA       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_a,
    input  logic [NB-1:0]       we_a,
    input  logic [WA-1:0]       addr_a,
    input  logic [LEN_DATA-1:0] din_a,
    output logic [LEN_DATA-1:0] q_a,
    input  logic [WA-1:0]       addr_b,
    output logic [LEN_DATA-1:0] q_b
);

    logic [LEN_DATA-1:0] mem [DEPTH];

    // Per-byte writes on port A.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
        end
    end

    // Port A read sees the contents from before this edge's write.
    always_ff @(posedge clk) begin
        if (!rst_n) q_a <= '0;
        else if (en_a) q_a <= mem[addr_a];
    end

    // Debug read runs every cycle, regardless of the pipeline enable.
    always_ff @(posedge clk) begin
        if (!rst_n) q_b <= '0;
        else q_b <= mem[addr_b];
    end

endmodule

// File: rtl/data_mem_bytewise.sv
// MIPS MEM-stage data memory: sized loads/stores, alignment faults,
// post-reset zero fill and a live debug read port.
module data_mem_bytewise
    import mips_mem_pkg::*;
#(
    parameter int    LEN_DATA       = 32,
    parameter int    RAM_DEPTH      = 256,
    parameter int    OUT_REG        = 0,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = "",
    localparam int   NB             = LEN_DATA / 8,
    localparam int   LW             = clogb2(NB),
    localparam int   WA             = clogb2(RAM_DEPTH),
    localparam int   AW             = WA + LW
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ctrl_clk_mips,
    data_mem_bytewise_if.slave  bus,
    input  logic [WA-1:0]       Dbg_Addr,
    output logic [LEN_DATA-1:0] Out_Data_debug
);

    // A preloaded image must survive reset, so it disables the fill.
    localparam bit CLEAR_EN = (CLEAR_ON_RESET != 0) && (INIT_FILE == "");

    clr_state_t          state_q, state_d;
    logic [WA-1:0]       cnt_q, cnt_d;
    logic                busy, clearing, acc, rd_en, mis;
    logic [LW-1:0]       lane;
    logic [WA-1:0]       widx;
    logic [NB-1:0]       size_mask, we_a;
    logic [WA-1:0]       addr_a;
    logic [LEN_DATA-1:0] din_a, q_a;
    logic [LW-1:0]       lane_q;
    logic [1:0]          size_q;
    logic                uns_q, mis_q;
    logic [LEN_DATA-1:0] sh, keep, ext, load_val;
    logic                sbit;

    assign busy     = (state_q != ST_READY);
    assign clearing = (state_q == ST_CLEAR);
    assign lane     = bus.Addr[LW-1:0];
    assign widx     = bus.Addr[AW-1:LW];
    assign acc      = !busy && ctrl_clk_mips && (bus.Rd || bus.Wr);
    assign rd_en    = acc && bus.Rd;
    assign bus.Busy = busy;

    // Clear sequencer state and word counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sequencer next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RST: begin
                cnt_d   = '0;
                state_d = CLEAR_EN ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                if (cnt_q == WA'(RAM_DEPTH - 1)) state_d = ST_READY;
                else cnt_d = cnt_q + 1'b1;
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_RST;
        endcase
    end

    // Alignment fault and unshifted byte-enable pattern per size.
    always_comb begin
        mis       = 1'b0;
        size_mask = '0;
        unique case (bus.Size)
            SIZE_BYTE: size_mask = NB'(1);
            SIZE_HALF: begin
                size_mask = NB'(3);
                mis       = bus.Addr[0];
            end
            SIZE_WORD: begin
                size_mask = NB'(8'h0F);
                mis       = (bus.Addr[1:0] != 2'b00);
            end
            SIZE_DWORD: begin
                size_mask = '1;
                mis       = (LEN_DATA == 32) || (bus.Addr[2:0] != 3'b000);
            end
        endcase
    end

    // Port A mux: the clear sequencer owns the RAM while busy.
    always_comb begin
        we_a   = '0;
        din_a  = '0;
        addr_a = widx;
        if (clearing) begin
            we_a   = '1;
            addr_a = cnt_q;
        end else if (acc && bus.Wr && !mis) begin
            we_a  = size_mask << lane;
            din_a = bus.In_Data << {lane, 3'b000};
        end
    end

    data_mem_bram #(
        .LEN_DATA (LEN_DATA),
        .DEPTH    (RAM_DEPTH),
        .NB       (NB),
        .WA       (WA)
    ) u_bram (
        .clk    (clk),
        .rst_n  (reset_n),
        .en_a   (rd_en),
        .we_a   (we_a),
        .addr_a (addr_a),
        .din_a  (din_a),
        .q_a    (q_a),
        .addr_b (Dbg_Addr),
        .q_b    (Out_Data_debug)
    );

    // Load attributes travel alongside the RAM read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lane_q <= '0;
            size_q <= SIZE_BYTE;
            uns_q  <= 1'b0;
            mis_q  <= 1'b0;
        end else if (rd_en) begin
            lane_q <= lane;
            size_q <= bus.Size;
            uns_q  <= bus.Unsigned;
            mis_q  <= mis;
        end
    end

    // Lane extract and sign/zero extension of the read word.
    always_comb begin
        sh   = q_a >> {lane_q, 3'b000};
        keep = '1;
        sbit = sh[LEN_DATA-1];
        unique case (size_q)
            SIZE_BYTE: begin
                keep = LEN_DATA'(8'hFF);
                sbit = sh[7];
            end
            SIZE_HALF: begin
                keep = LEN_DATA'(16'hFFFF);
                sbit = sh[15];
            end
            SIZE_WORD: begin
                keep = LEN_DATA'(32'hFFFF_FFFF);
                sbit = sh[31];
            end
            SIZE_DWORD: begin
                keep = '1;
                sbit = sh[LEN_DATA-1];
            end
        endcase
        ext      = (sh & keep) | ((!uns_q && sbit) ? ~keep : '0);
        load_val = mis_q ? '0 : ext;
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [LEN_DATA-1:0] data_r;
            logic                mis_r;
            // Extra output stage, frozen with the rest of the pipeline.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    data_r <= '0;
                    mis_r  <= 1'b0;
                end else if (ctrl_clk_mips && !busy) begin
                    data_r <= load_val;
                    mis_r  <= mis_q;
                end
            end
            assign bus.Out_Data   = data_r;
            assign bus.Misaligned = mis_r;
        end else begin : g_noreg
            assign bus.Out_Data   = load_val;
            assign bus.Misaligned = mis_q;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_bytewise.sv
// Self-checking bench for data_mem_bytewise (32-bit, 16 words).
// Directed test-plan steps followed by randomized loads/stores.
module tb_data_mem_bytewise;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ctrl_clk_mips;
    logic [3:0]  Dbg_Addr;
    logic [31:0] Out_Data_debug;

    int checks = 0;
    int errors = 0;

    byte unsigned ref_mem [64];
    logic [31:0]  exp_out;
    logic         exp_mis;

    data_mem_bytewise_if #(.LEN_DATA(32), .AW(6)) bus ();

    data_mem_bytewise #(
        .LEN_DATA       (32),
        .RAM_DEPTH      (16),
        .OUT_REG        (0),
        .CLEAR_ON_RESET (1),
        .INIT_FILE      ("")
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctrl_clk_mips  (ctrl_clk_mips),
        .bus            (bus),
        .Dbg_Addr       (Dbg_Addr),
        .Out_Data_debug (Out_Data_debug)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic bit ref_mis(input int addr, input int sz);
        if (sz == 3) return 1'b1;
        return (addr % (1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int addr, input int sz,
                                             input bit uns);
        int          n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[addr+i]) << (8*i));
        if (!uns && v[8*n-1]) v = v - (64'd1 << (8*n));
        return v[31:0];
    endfunction

    task automatic access(input bit rd, input bit wr, input int addr,
                          input int sz, input bit uns, input logic [31:0] d,
                          input bit en);
        bit m;
        bus.Rd       = rd;
        bus.Wr       = wr;
        bus.Addr     = 6'(addr);
        bus.Size     = 2'(sz);
        bus.Unsigned = uns;
        bus.In_Data  = d;
        ctrl_clk_mips = en;
        m = ref_mis(addr, sz);
        if (en && rd) begin
            exp_mis = m;
            exp_out = m ? 32'h0 : ref_load(addr, sz, uns);
        end
        if (en && wr && !m) begin
            for (int i = 0; i < (1 << sz); i++)
                ref_mem[addr+i] = byte'(d >> (8*i));
        end
        step();
        bus.Rd = 1'b0;
        bus.Wr = 1'b0;
        ctrl_clk_mips = 1'b1;
    endtask

    task automatic debug_scan(input string tag);
        for (int w = 0; w < 16; w++) begin
            Dbg_Addr = 4'(w);
            step();
            check(tag, Out_Data_debug, ref_word(w));
        end
    endtask

    task automatic reset_and_wait(input string tag);
        int n;
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (!bus.Busy) break;
        end
        check(tag, 32'(n), 32'd17);
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        exp_out = 32'h0;
        exp_mis = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        ctrl_clk_mips = 1'b1;
        Dbg_Addr      = '0;
        bus.Rd        = 1'b0;
        bus.Wr        = 1'b0;
        bus.Addr      = '0;
        bus.Size      = 2'b00;
        bus.Unsigned  = 1'b0;
        bus.In_Data   = '0;
        exp_out       = '0;
        exp_mis       = 1'b0;

        repeat (3) step();
        check("rst_busy", 32'(bus.Busy), 32'd1);
        check("rst_out", bus.Out_Data, 32'h0);
        check("rst_mis", 32'(bus.Misaligned), 32'd0);
        check("rst_dbg", Out_Data_debug, 32'h0);

        reset_and_wait("busy_len");
        debug_scan("clear_dbg");

        access(0, 1, 5, 0, 0, 32'h0000_0080, 1);
        access(1, 0, 5, 0, 0, 32'h0, 1);
        check("lb", bus.Out_Data, 32'hFFFF_FF80);
        access(1, 0, 5, 0, 1, 32'h0, 1);
        check("lbu", bus.Out_Data, 32'h0000_0080);
        Dbg_Addr = 4'd1;
        step();
        check("sb_word1", Out_Data_debug, 32'h0000_8000);

        access(0, 1, 2, 1, 0, 32'h0000_BEEF, 1);
        access(1, 0, 2, 1, 0, 32'h0, 1);
        check("lh", bus.Out_Data, 32'hFFFF_BEEF);
        access(1, 0, 0, 2, 0, 32'h0, 1);
        check("lw0", bus.Out_Data, 32'hBEEF_0000);

        access(1, 0, 6, 2, 0, 32'h0, 1);
        check("mis_flag", 32'(bus.Misaligned), 32'd1);
        check("mis_data", bus.Out_Data, 32'h0);
        access(0, 1, 6, 2, 0, 32'hDEAD_BEEF, 1);
        Dbg_Addr = 4'd1;
        step();
        check("mis_store", Out_Data_debug, 32'h0000_8000);

        access(1, 1, 12, 2, 0, 32'h1234_5678, 1);
        check("rf_old", bus.Out_Data, 32'h0);
        check("rf_mis", 32'(bus.Misaligned), 32'd0);
        access(1, 0, 12, 2, 0, 32'h0, 1);
        check("rf_new", bus.Out_Data, 32'h1234_5678);

        access(1, 1, 8, 2, 0, 32'hCAFE_F00D, 0);
        check("hold_out", bus.Out_Data, 32'h1234_5678);
        Dbg_Addr = 4'd2;
        step();
        check("hold_nowr", Out_Data_debug, 32'h0);

        for (int k = 0; k < 300; k++) begin
            int a;
            int s;
            a = int'($urandom_range(0, 63));
            s = int'($urandom_range(0, 3));
            access(1'($urandom), 1'($urandom), a, s, 1'($urandom),
                   $urandom, ($urandom_range(0, 7) != 0));
            check("rnd_out", bus.Out_Data, exp_out);
            check("rnd_mis", 32'(bus.Misaligned), 32'(exp_mis));
        end
        debug_scan("rnd_dbg");

        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (8) step();
        check("mid_busy", 32'(bus.Busy), 32'd1);
        reset_n = 1'b0;
        step();
        check("rst2_out", bus.Out_Data, 32'h0);
        reset_and_wait("busy_len2");
        debug_scan("clear2_dbg");
        access(1, 0, 12, 2, 0, 32'h0, 1);
        check("post_lw", bus.Out_Data, exp_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
